// File: rtl/aes_pkg.sv
// Shared AES definitions: schedule FSM encoding, AES-128 constants and the
// byte/word helpers used by the key schedule.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    CALC = 2'd2
  } ks_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam int         AES_NR    = 10;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/S4.sv
// Four AES S-boxes on one 32-bit word, registered output (1-cycle latency).
// Each byte is computed as the GF(2^8) inverse followed by the AES affine map.
module S4
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] sub_d;

  assign sub_d = {sub_byte(word_i[31:24]), sub_byte(word_i[23:16]),
                  sub_byte(word_i[15:8]),  sub_byte(word_i[7:0])};

  always_ff @(posedge clk) begin
    word_o <= sub_d;
  end

endmodule

// File: rtl/key_expand_step.sv
// One AES-128 key expansion step: derives the next round key from the current
// one, the substituted rotated last word and the round constant.
module key_expand_step (
  input  logic [127:0] key_i,
  input  logic [31:0]  subword_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] next_key_o
);

  logic [31:0] t;
  logic [31:0] w0n, w1n, w2n, w3n;

  assign t   = subword_i ^ {rcon_i, 24'h000000};
  assign w0n = key_i[127:96] ^ t;
  assign w1n = key_i[95:64]  ^ w0n;
  assign w2n = key_i[63:32]  ^ w1n;
  assign w3n = key_i[31:0]   ^ w2n;

  assign next_key_o = {w0n, w1n, w2n, w3n};

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128 key schedule: emits round keys 0..10 (or 1..10) with a
// valid/ready handshake, one new key every two cycles when not stalled.
module aes_key_sched_iter
  import aes_pkg::*;
#(
  parameter int NR        = 10,
  parameter bit EMIT_KEY0 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic         busy,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes_key_sched_iter: NR must be %0d", AES_NR);
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ks_state_e    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;
  logic [31:0]  s4_in;
  logic [31:0]  subword;
  logic [127:0] next_key;

  // In IDLE the S-boxes look at key_in so that a start going straight to CALC
  // already finds SubWord of the new key waiting one cycle later.
  assign s4_in = rot_word((state_q == IDLE) ? key_in[31:0] : key_q[31:0]);

  S4 u_s4 (
    .clk    (clk),
    .word_i (s4_in),
    .word_o (subword)
  );

  key_expand_step u_step (
    .key_i      (key_q),
    .subword_i  (subword),
    .rcon_i     (rcon_q),
    .next_key_o (next_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          rcon_d  = RCON_INIT;
          round_d = '0;
          state_d = EMIT_KEY0 ? EMIT : CALC;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        key_d   = next_key;
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk_out   = rk_valid ? key_q : '0;
  assign rk_round = rk_valid ? round_q : '0;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Scoreboard bench for aes_key_sched_iter: a word-level FIPS-197 key expansion
// model predicts every round key; a negedge monitor checks each transfer.
module tb_aes_key_sched_iter;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
  } sbEntry_t;

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] SEQ_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         rkReady = 1'b1;
  logic [127:0] keyIn = '0;
  logic         busy, rkValid, done;
  logic [127:0] rkOut;
  logic [3:0]   rkRound;

  logic         start0 = 1'b0;
  logic [127:0] keyIn0 = '0;
  logic         busy0, rkValid0, done0;
  logic [127:0] rkOut0;
  logic [3:0]   rkRound0;

  int tests = 0;
  int fails = 0;
  int cycleCnt = 0;
  int startCycle = 0;
  int stallRun = 0;
  int xferCount = 0;
  bit readyRandom = 1'b0;
  bit timingCheck = 1'b0;
  bit doneExpected = 1'b0;
  bit stallValid = 1'b0;
  logic [127:0] stallKey;
  logic [3:0]   stallRound;

  sbEntry_t     sbQ[$];
  sbEntry_t     ent;
  logic [127:0] captured [0:10];
  logic [127:0] modelRk  [0:10];
  logic [7:0]   sbox     [0:255];

  aes_key_sched_iter #(.NR(10), .EMIT_KEY0(1'b1)) u_dut (
    .clk(clk), .rst(rst), .key_in(keyIn), .start(start), .busy(busy),
    .rk_out(rkOut), .rk_round(rkRound), .rk_valid(rkValid),
    .rk_ready(rkReady), .done(done)
  );

  aes_key_sched_iter #(.NR(10), .EMIT_KEY0(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .key_in(keyIn0), .start(start0), .busy(busy0),
    .rk_out(rkOut0), .rk_round(rkRound0), .rk_valid(rkValid0),
    .rk_ready(1'b1), .done(done0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Classic generator walk over the multiplicative group (p by 3, q by 1/3).
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  task automatic computeModel(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc [0:9];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) modelRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic clearCaptured();
    for (int r = 0; r < 11; r++) captured[r] = '0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [127:0] key, input bit expectAccept);
    start = 1'b1;
    keyIn = key;
    if (expectAccept) begin
      computeModel(key);
      for (int r = 0; r < 11; r++) sbQ.push_back('{round: 4'(r), key: modelRk[r]});
    end
    @(posedge clk); #1;
    startCycle = cycleCnt;
    start = 1'b0;
    keyIn = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while ((busy || sbQ.size() != 0) && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy || sbQ.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL waitIdle: busy=%0b pending=%0d after %0d cycles", busy, sbQ.size(), n);
      sbQ.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Consumer model: random back-pressure, never more than 7 stalled cycles.
  always @(posedge clk) begin
    #1;
    if (readyRandom && stallRun < 7 && $urandom_range(0, 2) == 0) begin
      rkReady = 1'b0;
      stallRun++;
    end else begin
      rkReady = 1'b1;
      stallRun = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      doneExpected = 1'b0;
      stallValid   = 1'b0;
      xferCount    = 0;
    end else begin
      checkOutput("done", 128'(done), 128'(doneExpected));
      if (done && doneExpected) begin
        checkOutput("xferCount", 128'(xferCount), 128'(11));
        if (timingCheck) checkOutput("doneCycle", 128'(cycleCnt - startCycle + 1), 128'(22));
        xferCount = 0;
      end
      doneExpected = 1'b0;
      if (stallValid) begin
        checkOutput("stallRound", {123'(0), rkValid, rkRound}, {123'(0), 1'b1, stallRound});
        checkOutput("stallKey", rkOut, stallKey);
      end
      stallValid = rkValid && !rkReady;
      stallKey   = rkOut;
      stallRound = rkRound;
      if (rkValid && rkReady) begin
        if (sbQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpectedXfer: got round %0d, expected no transfer", rkRound);
        end else begin
          ent = sbQ.pop_front();
          checkOutput("rkRound", 128'(rkRound), 128'(ent.round));
          checkOutput("rkOut", rkOut, ent.key);
          if (timingCheck)
            checkOutput("rkCycle", 128'(cycleCnt - startCycle + 1), 128'(1 + 2 * int'(ent.round)));
        end
        if (rkRound <= 4'd10) captured[rkRound] = rkOut;
        xferCount++;
        if (rkRound == 4'd10) doneExpected = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int s0;
    int nextRound;
    int doneSeen;
    buildSbox();
    clearCaptured();

    #2 rst = 1'b1;
    #1;
    checkOutput("resetRkOut", rkOut, '0);
    checkOutput("resetRkRound", 128'(rkRound), 128'(0));
    checkOutput("resetRkValid", 128'(rkValid), 128'(0));
    checkOutput("resetBusy", 128'(busy), 128'(0));
    checkOutput("resetDone", 128'(done), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] scenario 1: FIPS-197 key, consumer always ready");
    timingCheck = 1'b1;
    @(posedge clk); #1;
    applyStimulus(FIPS_KEY, 1'b1);
    waitIdle(60);
    timingCheck = 1'b0;
    checkOutput("s1Round0", captured[0], FIPS_KEY);
    checkOutput("s1Round1", captured[1], FIPS_R1);
    checkOutput("s1Round10", captured[10], FIPS_R10);

    $display("[TB] scenario 2: FIPS-197 key with random back-pressure");
    clearCaptured();
    readyRandom = 1'b1;
    @(posedge clk); #1;
    applyStimulus(FIPS_KEY, 1'b1);
    waitIdle(400);
    checkOutput("s2Round1", captured[1], FIPS_R1);
    checkOutput("s2Round10", captured[10], FIPS_R10);

    $display("[TB] scenario 3: start pulsed while busy");
    @(posedge clk); #1;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    keyIn = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle(400);

    $display("[TB] random keys with random back-pressure");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      waitIdle(400);
    end
    readyRandom = 1'b0;

    $display("[TB] scenario 5: start in the done cycle");
    clearCaptured();
    @(posedge clk); #1;
    applyStimulus(FIPS_KEY, 1'b1);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL waitDone: got done=0 after %0d cycles, expected done=1", n);
    end
    applyStimulus(SEQ_KEY, 1'b1);
    waitIdle(60);
    checkOutput("s5Round10", captured[10], SEQ_R10);

    $display("[TB] scenario 4: reset in CALC after round 5");
    @(posedge clk); #1;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    n = 0;
    while (!(rkValid && rkRound == 4'd5) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sbQ.delete();
    checkOutput("s4RkOut", rkOut, '0);
    checkOutput("s4RkRound", 128'(rkRound), 128'(0));
    checkOutput("s4RkValid", 128'(rkValid), 128'(0));
    checkOutput("s4Busy", 128'(busy), 128'(0));
    checkOutput("s4Done", 128'(done), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    clearCaptured();
    @(posedge clk); #1;
    applyStimulus('0, 1'b1);
    waitIdle(60);
    checkOutput("s4ZeroRound1", captured[1], ZERO_R1);

    $display("[TB] scenario 6: EMIT_KEY0=0 instance");
    computeModel(FIPS_KEY);
    @(posedge clk); #1;
    start0 = 1'b1;
    keyIn0 = FIPS_KEY;
    @(posedge clk); #1;
    s0 = cycleCnt;
    start0 = 1'b0;
    keyIn0 = {$urandom, $urandom, $urandom, $urandom};
    nextRound = 1;
    doneSeen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rkValid0) begin
        checkOutput("s6Round", 128'(rkRound0), 128'(nextRound));
        checkOutput("s6Cycle", 128'(cycleCnt - s0 + 1), 128'(2 * nextRound));
        if (nextRound <= 10) checkOutput("s6Key", rkOut0, modelRk[nextRound]);
        nextRound++;
      end
      if (done0) doneSeen++;
    end
    checkOutput("s6Transfers", 128'(nextRound - 1), 128'(10));
    checkOutput("s6DonePulses", 128'(doneSeen), 128'(1));
    checkOutput("s6Round1", modelRk[1], FIPS_R1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
